// File: rtl/sync_event_queue_pkg.sv
// Shared widths and helpers for the synchronized-event interval queue.
// Imported by the storage sub-module and by the top level.
package sync_event_queue_pkg;

    localparam int EVQ_ADDR_W     = 2;
    localparam int EVQ_INTERVAL_W = 16;

    // Increment that sticks at the all-ones value of a width-bit field.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/sync_event_fifo.sv
// First-word-fall-through register-array queue with occupancy count.
// The caller decides legality of push/pop; this block just applies them.
module sync_event_fifo
    import sync_event_queue_pkg::*;
#(
    parameter int ADDR_W = EVQ_ADDR_W,
    parameter int DATA_W = EVQ_INTERVAL_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;

    // NOTE: the array is reset so the head reads 0 after reset; at this depth
    // a reset on storage costs little and removes X from the output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == (ADDR_W + 1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/sync_event_queue.sv
// Timestamps synchronized event pulses with the cycle interval since the
// previous pulse and queues them for a valid/ready consumer.
module sync_event_queue
    import sync_event_queue_pkg::*;
#(
    parameter int ADDR_W     = EVQ_ADDR_W,
    parameter int INTERVAL_W = EVQ_INTERVAL_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sync_pulse,
    input  logic                  event_ready,
    input  logic                  clear_overflow,
    output logic                  event_valid,
    output logic [INTERVAL_W-1:0] event_interval,
    output logic [ADDR_W:0]       pending,
    output logic                  overflow
);

    logic [INTERVAL_W-1:0] icnt;
    logic [INTERVAL_W-1:0] candidate;
    logic                  full;
    logic                  empty;
    logic                  do_push;
    logic                  do_pop;
    logic                  drop;

    assign candidate = INTERVAL_W'(sat_inc(32'(icnt), INTERVAL_W));

    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign do_pop      = !empty && event_ready;
    assign do_push     = sync_pulse && (!full || do_pop);
    assign drop        = sync_pulse && full && !do_pop;
    assign event_valid = !empty;

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            icnt <= '0;
        end else if (sync_pulse) begin
            icnt <= '0;
        end else begin
            icnt <= candidate;
        end
    end

    // A drop wins over a simultaneous clear so the loss is never hidden.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    sync_event_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (INTERVAL_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (do_push),
        .pop     (do_pop),
        .wdata   (candidate),
        .rdata   (event_interval),
        .full    (full),
        .empty   (empty),
        .count   (pending)
    );

endmodule
